// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, result classes, bus widths and divider states for the EX stage
package ex_pkg;

    localparam int REG_W     = 32;
    localparam int ALU_OP_W  = 8;
    localparam int ALU_SEL_W = 3;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b00011011;

    // SPECIAL function field codes decoded by the ID stage
    localparam logic [5:0] EXE_DIV  = 6'b011010;
    localparam logic [5:0] EXE_DIVU = 6'b011011;

    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - restoring divider, one quotient bit per cycle, with sign fixup on completion
module ex_div_unit
    import ex_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [REG_W-1:0]  opdata1,
    input  logic [REG_W-1:0]  opdata2,
    input  logic              annul,
    output logic [2*REG_W-1:0] result,
    output logic              ready
);

    localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    div_state_e        state_q, state_d;
    logic [REG_W-1:0]  quot_q, quot_d;
    logic [REG_W-1:0]  rem_q, rem_d;
    logic [REG_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;

    logic [REG_W:0]    rem_shift;
    logic [REG_W+1:0]  trial;
    logic [REG_W-1:0]  quot_fix;
    logic [REG_W-1:0]  rem_fix;

    // Dividend bits are shifted out of the top of quot_q into the partial remainder
    assign rem_shift = {rem_q, quot_q[REG_W-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
    assign quot_fix  = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
    assign rem_fix   = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;

    always_comb begin
        state_d    = state_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result     = '0;
        ready      = 1'b0;

        case (state_q)
            DIV_FREE: begin
                if (start) begin
                    if (opdata2 == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        quot_d     = (signed_div && opdata1[REG_W-1]) ? (~opdata1 + 1'b1) : opdata1;
                        divisor_d  = (signed_div && opdata2[REG_W-1]) ? (~opdata2 + 1'b1) : opdata2;
                        rem_d      = '0;
                        cnt_d      = '0;
                        neg_quot_d = signed_div && (opdata1[REG_W-1] ^ opdata2[REG_W-1]);
                        neg_rem_d  = signed_div && opdata1[REG_W-1];
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                quot_d     = '0;
                rem_d      = '0;
                neg_quot_d = 1'b0;
                neg_rem_d  = 1'b0;
                state_d    = DIV_END;
            end
            DIV_ON: begin
                if (trial[REG_W+1]) begin
                    rem_d  = rem_shift[REG_W-1:0];
                    quot_d = {quot_q[REG_W-2:0], 1'b0};
                end else begin
                    rem_d  = trial[REG_W-1:0];
                    quot_d = {quot_q[REG_W-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                result  = {rem_fix, quot_fix};
                ready   = 1'b1;
                state_d = DIV_FREE;
            end
            default: state_d = DIV_FREE;
        endcase

        if (annul) begin
            state_d = DIV_FREE;
            result  = '0;
            ready   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= DIV_FREE;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

endmodule

// File: rtl/ex.sv
// rtl/ex.sv - MIPS execute stage: logic/shift result mux, divider hookup and stall request
module ex
    import ex_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALU_OP_W-1:0]  aluop_i,
    input  logic [ALU_SEL_W-1:0] alusel_i,
    input  logic [REG_W-1:0]     reg1_i,
    input  logic [REG_W-1:0]     reg2_i,
    input  logic [4:0]           wd_i,
    input  logic                 wreg_i,
    input  logic                 annul_i,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
    output logic [REG_W-1:0]     wdata_o,
    output logic                 whilo_o,
    output logic [REG_W-1:0]     hi_o,
    output logic [REG_W-1:0]     lo_o,
    output logic                 stallreq_o
);

    logic                 is_div;
    logic [2*REG_W-1:0]   div_result;
    logic                 div_ready;
    logic [REG_W-1:0]     logic_res;
    logic [REG_W-1:0]     shift_res;
    logic signed [REG_W-1:0] sra_src;
    logic [4:0]           shamt;

    assign is_div  = is_div_op(aluop_i);
    assign shamt   = reg1_i[4:0];
    assign sra_src = reg2_i;

    ex_div_unit #(
        .DIV_ITER(DIV_ITER)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div),
        .signed_div (aluop_i == EXE_DIV_OP),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .annul      (annul_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << shamt;
            EXE_SRL_OP: shift_res = reg2_i >> shamt;
            EXE_SRA_OP: shift_res = sra_src >>> shamt;
            default:    shift_res = '0;
        endcase
    end

    // Everything is held at zero while reset is asserted, even before the first edge
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !is_div;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                default:       wdata_o = '0;
            endcase
            whilo_o    = div_ready;
            hi_o       = div_result[2*REG_W-1:REG_W];
            lo_o       = div_result[REG_W-1:0];
            stallreq_o = is_div && !div_ready && !annul_i;
        end
    end

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - directed vector and sequence bench for the execute stage
module tb_ex;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        annul;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    ex #(.DIV_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .annul_i    (annul),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        aluop  = EXE_NOP_OP;
        alusel = EXE_RES_NOP;
        reg1   = '0;
        reg2   = '0;
        wd     = '0;
        wreg   = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_whilo"}, {31'b0, whilo_o}, 32'd0);
        chk({name, "_hi"}, hi_o, 32'd0);
        chk({name, "_lo"}, lo_o, 32'd0);
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input int exp_stall, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   n;
        logic early;
        n     = 0;
        early = 1'b0;
        @(negedge clk);
        aluop  = op;
        alusel = EXE_RES_NOP;
        reg1   = r1;
        reg2   = r2;
        wd     = 5'd9;
        wreg   = 1'b1;
        #1;
        chk("div_wreg_o", {31'b0, wreg_o}, 32'd0);
        chk("div_wd_o", {27'b0, wd_o}, 32'd9);
        while (stallreq_o === 1'b1 && n < 200) begin
            if (whilo_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) early = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        chk("div_quiet_while_stalled", {31'b0, early}, 32'd0);
        chk("div_stall_cycles", 32'(n), 32'(exp_stall));
        chk("div_done_whilo", {31'b0, whilo_o}, 32'd1);
        chk("div_done_stall", {31'b0, stallreq_o}, 32'd0);
        chk("div_lo", lo_o, exp_lo);
        chk("div_hi", hi_o, exp_hi);
    endtask

    initial begin
        vecs[0]  = '{EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd5,  1'b1, 32'h00FFF0F0};
        vecs[1]  = '{EXE_AND_OP, EXE_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd1,  1'b1, 32'h0F000F00};
        vecs[2]  = '{EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd31, 1'b1, 32'hF0F00F0F};
        vecs[3]  = '{EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd7,  1'b0, 32'hFF000F0F};
        vecs[4]  = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'h00000004, 32'h80000010, 5'd2,  1'b1, 32'hF8000001};
        vecs[5]  = '{EXE_SRL_OP, EXE_RES_SHIFT, 32'h00000004, 32'h80000010, 5'd3,  1'b1, 32'h08000001};
        vecs[6]  = '{EXE_SLL_OP, EXE_RES_SHIFT, 32'hFFFFFFE4, 32'h80000010, 5'd4,  1'b1, 32'h00000100};
        vecs[7]  = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000001F, 32'h80000000, 5'd8,  1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{EXE_SRL_OP, EXE_RES_SHIFT, 32'h0000001F, 32'h80000000, 5'd9,  1'b1, 32'h00000001};
        vecs[9]  = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'h00000000, 32'h7FFFFFFF, 5'd10, 1'b1, 32'h7FFFFFFF};
        vecs[10] = '{EXE_NOP_OP, EXE_RES_NOP,   32'h12345678, 32'h9ABCDEF0, 5'd11, 1'b0, 32'h00000000};
        vecs[11] = '{EXE_OR_OP,  3'b111,        32'h12345678, 32'h9ABCDEF0, 5'd12, 1'b1, 32'h00000000};

        rst   = 1'b0;
        annul = 1'b0;
        aluop  = EXE_OR_OP;
        alusel = EXE_RES_LOGIC;
        reg1   = 32'h0000F0F0;
        reg2   = 32'h00FF0000;
        wd     = 5'd5;
        wreg   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", {27'b0, wd_o}, 32'd0);
        chk("rst_wreg", {31'b0, wreg_o}, 32'd0);
        chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
        check_quiet("rst");

        @(negedge clk);
        rst = 1'b1;
        drive_nop();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            aluop  = vecs[i].aluop;
            alusel = vecs[i].alusel;
            reg1   = vecs[i].reg1;
            reg2   = vecs[i].reg2;
            wd     = vecs[i].wd;
            wreg   = vecs[i].wreg;
            #1;
            chk($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp_wdata);
            chk($sformatf("vec%0d_wd", i), {27'b0, wd_o}, {27'b0, vecs[i].wd});
            chk($sformatf("vec%0d_wreg", i), {31'b0, wreg_o}, {31'b0, vecs[i].wreg});
            chk($sformatf("vec%0d_stall", i), {31'b0, stallreq_o}, 32'd0);
            chk($sformatf("vec%0d_whilo", i), {31'b0, whilo_o}, 32'd0);
        end

        run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div(EXE_DIVU_OP, 32'hFFFFFFF9, 32'd2, 33, 32'h7FFFFFFC, 32'h00000001);
        run_div(EXE_DIV_OP, 32'd5, 32'd0, 2, 32'd0, 32'd0);
        run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);
        // second division issued in the cycle right after DONE
        run_div(EXE_DIV_OP, 32'd100, 32'hFFFFFFF9, 33, 32'hFFFFFFF2, 32'd2);
        @(negedge clk);
        drive_nop();
        #1;
        check_quiet("after_done");

        begin
            logic pulse;
            pulse = 1'b0;
            @(negedge clk);
            aluop  = EXE_DIVU_OP;
            alusel = EXE_RES_NOP;
            reg1   = 32'd100;
            reg2   = 32'd7;
            for (int i = 0; i < 11; i++) @(negedge clk);
            annul = 1'b1;
            #1;
            chk("annul_stall", {31'b0, stallreq_o}, 32'd0);
            chk("annul_whilo", {31'b0, whilo_o}, 32'd0);
            @(negedge clk);
            annul = 1'b0;
            drive_nop();
            #1;
            chk("post_annul_stall", {31'b0, stallreq_o}, 32'd0);
            for (int i = 0; i < 40; i++) begin
                if (whilo_o !== 1'b0) pulse = 1'b1;
                @(negedge clk);
                #1;
            end
            chk("annul_no_whilo", {31'b0, pulse}, 32'd0);
        end
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);

        @(negedge clk);
        aluop  = EXE_DIVU_OP;
        alusel = EXE_RES_LOGIC;
        reg1   = 32'd100;
        reg2   = 32'd7;
        wd     = 5'd5;
        wreg   = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, stallreq_o}, 32'd0);
        chk("midrst_wd", {27'b0, wd_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("midrst_held_stall", {31'b0, stallreq_o}, 32'd0);
        chk("midrst_held_wd", {27'b0, wd_o}, 32'd0);
        chk("midrst_held_wdata", wdata_o, 32'd0);
        check_quiet("midrst_held");
        @(negedge clk);
        drive_nop();
        rst = 1'b1;
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        @(negedge clk);
        drive_nop();
        #1;
        check_quiet("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
